onewire_temp_slave: RTL and testbench

- 1-Wire responder emulating a DS18B20 temperature sensor; the device-side counterpart of the 1-wire temperature master.
- Lets master benches and loop-back FPGA builds run the full master flow with no physical sensor: reset/presence, skip ROM, convert T, read scratchpad with CRC.
- Sits on the slave side of the open-drain DQ line. It drives the line low only; the pull-up is external.

---
 rtl/onewire_pkg.sv | 37 +++
 rtl/onewire_crc8.sv | 37 +++
 rtl/onewire_temp_slave.sv | 254 +++++++++++++++++++++++++
 tb/tb_onewire_temp_slave.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/onewire_pkg.sv
// Shared definitions for the 1-Wire temperature slave and its master.
package onewire_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PD_WAIT,
        ST_PD_DRIVE,
        ST_ROM_RX,
        ST_FN_RX,
        ST_CONVERT,
        ST_TX_SCR
    } ow_state_t;

    localparam logic [7:0] CMD_SKIP_ROM = 8'hCC;
    localparam logic [7:0] CMD_CONVERT  = 8'h44;
    localparam logic [7:0] CMD_READ_SCR = 8'hBE;

    // Fixed scratchpad bytes 2..7 (TH, TL, config, reserved x3)
    localparam logic [7:0] SCR_TH   = 8'h4B;
    localparam logic [7:0] SCR_TL   = 8'h46;
    localparam logic [7:0] SCR_CFG  = 8'h7F;
    localparam logic [7:0] SCR_RES0 = 8'hFF;
    localparam logic [7:0] SCR_RES1 = 8'h0C;
    localparam logic [7:0] SCR_RES2 = 8'h10;

    // Dallas CRC-8 polynomial x^8+x^5+x^4+1, reflected
    localparam logic [7:0] CRC8_POLY = 8'h8C;

    // Power-on temperature, +85 degC
    localparam logic [15:0] TEMP_POR = 16'h0550;

    // Scratchpad bytes 0..7 packed with byte 0 in the low bits, ready to shift out LSB first
    function automatic logic [63:0] scratch_image(input logic [15:0] t);
        return {SCR_RES2, SCR_RES1, SCR_RES0, SCR_CFG, SCR_TL, SCR_TH, t};
    endfunction

endpackage

// File: rtl/onewire_crc8.sv
// Serial bit-in Dallas CRC-8 (reflected), shared by the slave and the master.
module onewire_crc8
    import onewire_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [7:0] crc
);

    logic [7:0] crc_reg;
    logic [7:0] crc_next;
    logic       fb;

    assign fb = crc_reg[0] ^ bit_in;

    genvar gi;
    for (gi = 0; gi < 8; gi++) begin : g_crc
        if (gi == 7) begin : g_msb
            assign crc_next[gi] = fb & CRC8_POLY[gi];
        end else begin : g_low
            assign crc_next[gi] = crc_reg[gi+1] ^ (fb & CRC8_POLY[gi]);
        end
    end

    // CRC register: clear has priority over shifting in a new bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      crc_reg <= 8'h00;
        else if (clr) crc_reg <= 8'h00;
        else if (en)  crc_reg <= crc_next;
    end

    assign crc = crc_reg;

endmodule

// File: rtl/onewire_temp_slave.sv
// DS18B20-style 1-Wire responder: presence, skip ROM, convert T, read scratchpad.
module onewire_temp_slave
    import onewire_pkg::*;
#(
    parameter int unsigned RST_MIN  = 60000,
    parameter int unsigned PD_WAIT  = 3750,
    parameter int unsigned PD_LOW   = 15000,
    parameter int unsigned T_SAMPLE = 3750,
    parameter int unsigned T_HOLD0  = 3750,
    parameter int unsigned CONV_CYC = 125000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dq_in,
    output logic        dq_oe,
    input  logic [15:0] t_value,
    output logic        conv_done,
    output logic        cmd_stb,
    output logic [7:0]  cmd_code,
    output logic        busy
);

    logic        sync_reg, dq_s_reg, dq_prev_reg, dq_oe_prev_reg;
    logic [1:0]  blank_reg;
    logic [31:0] low_cnt_reg;

    ow_state_t   state_reg, state_next;
    logic [31:0] cnt_reg, cnt_next;
    logic [6:0]  bit_cnt_reg, bit_cnt_next;
    logic [7:0]  rx_reg, rx_next;
    logic        samp_pend_reg, samp_pend_next;
    logic [31:0] samp_cnt_reg, samp_cnt_next;
    logic        hold_reg, hold_next;
    logic [31:0] hold_cnt_reg, hold_cnt_next;
    logic [15:0] temp_reg, temp_next;
    logic [63:0] scr_reg, scr_next;
    logic        busy_reg, busy_next;
    logic        conv_done_reg, conv_done_next;
    logic        cmd_stb_reg, cmd_stb_next;
    logic [7:0]  cmd_code_reg, cmd_code_next;

    logic        crc_clr, crc_en;
    logic [7:0]  crc_val;
    logic        fall, rise, line_reset, slot_fall, samp_now, tx_bit;
    logic [7:0]  rx_byte;

    onewire_crc8 u_crc (
        .clk    (clk),
        .rst    (rst),
        .clr    (crc_clr),
        .en     (crc_en),
        .bit_in (scr_reg[0]),
        .crc    (crc_val)
    );

    // Presence pulse or a read-0 hold pulls the line low
    assign dq_oe = (state_reg == ST_PD_DRIVE) || hold_reg;

    assign fall       = dq_prev_reg & ~dq_s_reg;
    assign rise       = ~dq_prev_reg & dq_s_reg;
    assign line_reset = rise && (low_cnt_reg == RST_MIN);
    // Our own drive produces line edges; ignore them until shortly after release
    assign slot_fall  = fall & ~dq_oe & ~dq_oe_prev_reg & (blank_reg == 2'd0);
    assign samp_now   = samp_pend_reg && (samp_cnt_reg == T_SAMPLE);
    assign rx_byte    = {dq_s_reg, rx_reg[7:1]};
    assign tx_bit     = (bit_cnt_reg < 7'd64) ? scr_reg[0] : crc_val[bit_cnt_reg[2:0]];

    // Input synchroniser, edge history, low-time counter and self-drive blanking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg       <= 1'b1;
            dq_s_reg       <= 1'b1;
            dq_prev_reg    <= 1'b1;
            dq_oe_prev_reg <= 1'b0;
            blank_reg      <= 2'd0;
            low_cnt_reg    <= '0;
        end else begin
            sync_reg       <= dq_in;
            dq_s_reg       <= sync_reg;
            dq_prev_reg    <= dq_s_reg;
            dq_oe_prev_reg <= dq_oe;
            if (dq_oe_prev_reg && !dq_oe) blank_reg <= 2'd2;
            else if (blank_reg != 2'd0)   blank_reg <= blank_reg - 2'd1;
            if (dq_s_reg)                  low_cnt_reg <= '0;
            else if (low_cnt_reg != RST_MIN) low_cnt_reg <= low_cnt_reg + 32'd1;
        end
    end

    // Protocol state and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            bit_cnt_reg   <= '0;
            rx_reg        <= '0;
            samp_pend_reg <= 1'b0;
            samp_cnt_reg  <= '0;
            hold_reg      <= 1'b0;
            hold_cnt_reg  <= '0;
            temp_reg      <= TEMP_POR;
            scr_reg       <= '0;
            busy_reg      <= 1'b0;
            conv_done_reg <= 1'b0;
            cmd_stb_reg   <= 1'b0;
            cmd_code_reg  <= 8'h00;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            bit_cnt_reg   <= bit_cnt_next;
            rx_reg        <= rx_next;
            samp_pend_reg <= samp_pend_next;
            samp_cnt_reg  <= samp_cnt_next;
            hold_reg      <= hold_next;
            hold_cnt_reg  <= hold_cnt_next;
            temp_reg      <= temp_next;
            scr_reg       <= scr_next;
            busy_reg      <= busy_next;
            conv_done_reg <= conv_done_next;
            cmd_stb_reg   <= cmd_stb_next;
            cmd_code_reg  <= cmd_code_next;
        end
    end

    // Next-state logic: slot timing, byte reception, conversion and transmit
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        bit_cnt_next   = bit_cnt_reg;
        rx_next        = rx_reg;
        samp_pend_next = samp_pend_reg;
        samp_cnt_next  = samp_cnt_reg;
        hold_next      = hold_reg;
        hold_cnt_next  = hold_cnt_reg;
        temp_next      = temp_reg;
        scr_next       = scr_reg;
        busy_next      = busy_reg;
        conv_done_next = 1'b0;
        cmd_stb_next   = 1'b0;
        cmd_code_next  = cmd_code_reg;
        crc_clr        = 1'b0;
        crc_en         = 1'b0;

        if (hold_reg) begin
            if (hold_cnt_reg == T_HOLD0) hold_next = 1'b0;
            else                         hold_cnt_next = hold_cnt_reg + 32'd1;
        end
        if (samp_pend_reg) samp_cnt_next = samp_cnt_reg + 32'd1;

        case (state_reg)
            ST_PD_WAIT: begin
                if (cnt_reg == PD_WAIT - 1) begin
                    state_next = ST_PD_DRIVE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 32'd1;
                end
            end
            ST_PD_DRIVE: begin
                if (cnt_reg == PD_LOW - 1) begin
                    state_next     = ST_ROM_RX;
                    cnt_next       = '0;
                    bit_cnt_next   = '0;
                    samp_pend_next = 1'b0;
                end else begin
                    cnt_next = cnt_reg + 32'd1;
                end
            end
            ST_ROM_RX, ST_FN_RX: begin
                if (slot_fall && !samp_pend_reg) begin
                    samp_pend_next = 1'b1;
                    samp_cnt_next  = 32'd1;
                end
                if (samp_now) begin
                    samp_pend_next = 1'b0;
                    rx_next        = rx_byte;
                    bit_cnt_next   = bit_cnt_reg + 7'd1;
                    if (bit_cnt_reg == 7'd7) begin
                        bit_cnt_next = '0;
                        if (state_reg == ST_ROM_RX) begin
                            state_next = (rx_byte == CMD_SKIP_ROM) ? ST_FN_RX : ST_IDLE;
                        end else begin
                            cmd_stb_next  = 1'b1;
                            cmd_code_next = rx_byte;
                            case (rx_byte)
                                CMD_CONVERT: begin
                                    state_next = ST_CONVERT;
                                    busy_next  = 1'b1;
                                    cnt_next   = '0;
                                end
                                CMD_READ_SCR: begin
                                    state_next = ST_TX_SCR;
                                    scr_next   = scratch_image(temp_reg);
                                    crc_clr    = 1'b1;
                                end
                                default: state_next = ST_IDLE;
                            endcase
                        end
                    end
                end
            end
            ST_CONVERT: begin
                if (busy_reg) begin
                    if (cnt_reg == CONV_CYC - 1) begin
                        temp_next      = t_value;
                        conv_done_next = 1'b1;
                        busy_next      = 1'b0;
                    end else begin
                        cnt_next = cnt_reg + 32'd1;
                    end
                end
                // Read slots answer 0 while converting, 1 (no drive) afterwards
                if (slot_fall && busy_reg) begin
                    hold_next     = 1'b1;
                    hold_cnt_next = 32'd1;
                end
            end
            ST_TX_SCR: begin
                if (slot_fall) begin
                    if (!tx_bit) begin
                        hold_next     = 1'b1;
                        hold_cnt_next = 32'd1;
                    end
                    if (bit_cnt_reg < 7'd64) begin
                        crc_en   = 1'b1;
                        scr_next = {1'b0, scr_reg[63:1]};
                    end
                    if (bit_cnt_reg == 7'd71) begin
                        state_next   = ST_IDLE;
                        bit_cnt_next = '0;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 7'd1;
                    end
                end
            end
            default: ;
        endcase

        // A long low pulse restarts the bus from any state and aborts conversion
        if (line_reset) begin
            state_next     = ST_PD_WAIT;
            cnt_next       = '0;
            bit_cnt_next   = '0;
            busy_next      = 1'b0;
            hold_next      = 1'b0;
            samp_pend_next = 1'b0;
        end
    end

    assign conv_done = conv_done_reg;
    assign cmd_stb   = cmd_stb_reg;
    assign cmd_code  = cmd_code_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_onewire_temp_slave.sv
// Directed bench for onewire_temp_slave with shortened timing parameters.
module tb_onewire_temp_slave;

    localparam int P_RST  = 600;
    localparam int P_PDW  = 40;
    localparam int P_PDL  = 150;
    localparam int P_TS   = 40;
    localparam int P_TH   = 40;
    localparam int P_CONV = 1250;
    localparam int SLOT   = 80;
    localparam int RST_LONG  = 625;   // ~500 us scaled
    localparam int RST_SHORT = 500;   // ~400 us scaled

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        master_low = 1'b0;
    logic [15:0] t_value = 16'h0000;
    logic        dq_in;
    logic        dq_oe, conv_done, cmd_stb, busy;
    logic [7:0]  cmd_code;

    // Open-drain bus: low if either side pulls
    assign dq_in = ~(master_low | dq_oe);

    onewire_temp_slave #(
        .RST_MIN (P_RST), .PD_WAIT (P_PDW), .PD_LOW (P_PDL),
        .T_SAMPLE(P_TS),  .T_HOLD0 (P_TH),  .CONV_CYC(P_CONV)
    ) dut (
        .clk(clk), .rst(rst), .dq_in(dq_in), .dq_oe(dq_oe), .t_value(t_value),
        .conv_done(conv_done), .cmd_stb(cmd_stb), .cmd_code(cmd_code), .busy(busy)
    );

    always #4 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model state
    logic [15:0] model_temp = 16'h0550;
    logic        model_busy = 1'b0;
    bit          busy_known = 1'b0;
    bit          quiet = 1'b0;
    logic [7:0]  model_cmd = 8'h00;
    int          stb_seen = 0;
    int          done_seen = 0;
    int          busy_cycles = 0;
    logic [7:0]  rx_bytes [0:8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] crc_byte(input logic [7:0] c_in, input logic [7:0] d);
        logic [7:0] c;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ d[i]) c = (c >> 1) ^ 8'h8C;
            else             c = c >> 1;
        end
        return c;
    endfunction

    function automatic logic [63:0] model_image(input logic [15:0] t);
        return {8'h10, 8'h0C, 8'hFF, 8'h7F, 8'h46, 8'h4B, t};
    endfunction

    // Per-cycle comparison of the DUT against the model
    always @(negedge clk) begin
        if (!rst) begin
            if (busy_known) check("busy_track", {31'd0, busy}, {31'd0, model_busy});
            if (quiet)      check("quiet_dq_oe", {31'd0, dq_oe}, 32'd0);
            if (cmd_stb) begin
                stb_seen++;
                check("cmd_code_on_stb", {24'd0, cmd_code}, {24'd0, model_cmd});
            end
            if (conv_done) done_seen++;
            if (busy)      busy_cycles++;
        end
    end

    task automatic line_reset(input int low_cyc, input bit expect_pd);
        int d;
        int w;
        busy_known = 1'b0;
        @(negedge clk);
        master_low = 1'b1;
        repeat (P_TH + 10) @(negedge clk);
        check("dq_oe_released_in_reset", {31'd0, dq_oe}, 32'd0);
        repeat (low_cyc - P_TH - 10) @(negedge clk);
        master_low = 1'b0;
        if (expect_pd) model_busy = 1'b0;
        d = 0;
        while (dq_oe !== 1'b1 && d < P_PDW + P_PDL + 50) begin
            @(negedge clk);
            d++;
        end
        if (expect_pd) begin
            check("pd_delay", {31'd0, (d >= P_PDW + 2 && d <= P_PDW + 3)}, 32'd1);
            w = 0;
            while (dq_oe === 1'b1 && w < P_PDL + 50) begin
                @(negedge clk);
                w++;
            end
            check("pd_width", w, P_PDL);
        end else begin
            check("no_presence", d, P_PDW + P_PDL + 50);
        end
        busy_known = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic write_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            master_low = 1'b1;
            repeat (b[i] ? 5 : 60) @(negedge clk);
            master_low = 1'b0;
            repeat (b[i] ? SLOT - 5 : SLOT - 60) @(negedge clk);
        end
    endtask

    task automatic read_bit(output logic b);
        @(negedge clk);
        master_low = 1'b1;
        repeat (3) @(negedge clk);
        master_low = 1'b0;
        repeat (12) @(negedge clk);
        b = dq_in;
        repeat (SLOT - 15) @(negedge clk);
    endtask

    task automatic read_scratch();
        logic b;
        for (int k = 0; k < 9; k++) begin
            for (int i = 0; i < 8; i++) begin
                read_bit(b);
                rx_bytes[k][i] = b;
            end
        end
    endtask

    task automatic start_read_scr();
        int s0;
        write_byte(8'hCC);
        s0 = stb_seen;
        model_cmd = 8'hBE;
        write_byte(8'hBE);
        check("stb_after_read_cmd", stb_seen - s0, 1);
    endtask

    task automatic check_scratch(input logic [15:0] t);
        logic [7:0] exp_b [0:7];
        logic [7:0] c;
        exp_b = '{t[7:0], t[15:8], 8'h4B, 8'h46, 8'h7F, 8'hFF, 8'h0C, 8'h10};
        c = 8'h00;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("scr_byte%0d", i), {24'd0, rx_bytes[i]}, {24'd0, exp_b[i]});
            c = crc_byte(c, exp_b[i]);
        end
        check("scr_crc", {24'd0, rx_bytes[8]}, {24'd0, c});
        c = 8'h00;
        for (int i = 0; i < 9; i++) c = crc_byte(c, rx_bytes[i]);
        check("scr_crc_residue", {24'd0, c}, 32'd0);
    endtask

    task automatic do_convert(input logic [15:0] t);
        logic b;
        int d0;
        int w;
        line_reset(RST_LONG, 1'b1);
        t_value = t;
        write_byte(8'hCC);
        model_cmd   = 8'h44;
        busy_cycles = 0;
        d0          = done_seen;
        busy_known  = 1'b0;
        write_byte(8'h44);
        model_busy = 1'b1;
        busy_known = 1'b1;
        for (int i = 0; i < 4; i++) begin
            read_bit(b);
            check("read_during_conv", {31'd0, b}, 32'd0);
        end
        busy_known = 1'b0;
        w = 0;
        while (done_seen == d0 && w < P_CONV + 100) begin
            @(negedge clk);
            w++;
        end
        model_busy = 1'b0;
        busy_known = 1'b1;
        model_temp = t;
        repeat (5) @(negedge clk);
        check("conv_done_pulses", done_seen - d0, 1);
        check("busy_cycles", busy_cycles, P_CONV);
        for (int i = 0; i < 4; i++) begin
            read_bit(b);
            check("read_after_conv", {31'd0, b}, 32'd1);
        end
    endtask

    initial begin
        logic        b;
        logic [63:0] img;
        int          s0;

        // Reset values
        repeat (5) @(negedge clk);
        check("rst_dq_oe", {31'd0, dq_oe}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_cmd_stb", {31'd0, cmd_stb}, 32'd0);
        check("rst_conv_done", {31'd0, conv_done}, 32'd0);
        check("rst_cmd_code", {24'd0, cmd_code}, 32'd0);
        rst = 1'b0;
        busy_known = 1'b1;
        repeat (5) @(negedge clk);

        // Pin the CRC model against known Dallas CRC-8 table entries
        check("crc_model_01", {24'd0, crc_byte(8'h00, 8'h01)}, 32'h5E);
        check("crc_model_02", {24'd0, crc_byte(8'h00, 8'h02)}, 32'hBC);

        // Short low pulse: no presence; long pulse: presence
        line_reset(RST_SHORT, 1'b0);
        line_reset(RST_LONG, 1'b1);

        // Scratchpad without conversion
        start_read_scr();
        read_scratch();
        check("por_byte0_literal", {24'd0, rx_bytes[0]}, 32'h50);
        check("por_byte1_literal", {24'd0, rx_bytes[1]}, 32'h05);
        check_scratch(model_temp);

        // Conversion with a positive value, then read back
        do_convert(16'h0191);
        line_reset(RST_LONG, 1'b1);
        start_read_scr();
        read_scratch();
        check_scratch(model_temp);

        // Conversion with a negative value
        do_convert(16'hFF5E);
        line_reset(RST_LONG, 1'b1);
        start_read_scr();
        read_scratch();
        check("neg_byte0_literal", {24'd0, rx_bytes[0]}, 32'h5E);
        check("neg_byte1_literal", {24'd0, rx_bytes[1]}, 32'hFF);
        check_scratch(model_temp);

        // Unsupported ROM command: bus stays quiet
        line_reset(RST_LONG, 1'b1);
        s0 = stb_seen;
        write_byte(8'h55);
        quiet = 1'b1;
        for (int i = 0; i < 16; i++) begin
            read_bit(b);
            check("unsupported_read", {31'd0, b}, 32'd1);
        end
        quiet = 1'b0;
        check("no_stb_after_55", stb_seen - s0, 0);
        line_reset(RST_LONG, 1'b1);

        // Line reset during bit 20 of scratchpad transmit
        start_read_scr();
        img = model_image(model_temp);
        for (int i = 0; i < 20; i++) begin
            read_bit(b);
            check($sformatf("partial_bit%0d", i), {31'd0, b}, {31'd0, img[i]});
        end
        line_reset(RST_LONG, 1'b1);
        start_read_scr();
        read_scratch();
        check_scratch(model_temp);

        // rst asserted mid-conversion while a read-0 is being driven
        line_reset(RST_LONG, 1'b1);
        t_value = 16'h1234;
        write_byte(8'hCC);
        model_cmd  = 8'h44;
        busy_known = 1'b0;
        write_byte(8'h44);
        repeat (5) @(negedge clk);
        check("busy_before_rst", {31'd0, busy}, 32'd1);
        @(negedge clk);
        master_low = 1'b1;
        repeat (3) @(negedge clk);
        master_low = 1'b0;
        repeat (10) @(negedge clk);
        check("conv_read_driving", {31'd0, dq_oe}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_dq_oe", {31'd0, dq_oe}, 32'd0);
        check("rst_async_busy", {31'd0, busy}, 32'd0);
        check("rst_async_cmd_code", {24'd0, cmd_code}, 32'd0);
        model_temp = 16'h0550;
        model_busy = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        busy_known = 1'b1;
        line_reset(RST_LONG, 1'b1);
        start_read_scr();
        read_scratch();
        check_scratch(model_temp);

        check("conv_done_total", done_seen, 2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog: the directed run is far shorter than this bound
    initial begin
        #(8 * 120000);
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
